// File: rtl/pipeline_types.sv
// Shared types for the count-enable datapath.
// Edge strobes, measurement FSM states and report bundle.
package pipeline_types;

  localparam int MEAS_WIDTH = 16;

  typedef struct packed {
    logic rising;
    logic falling;
  } edges_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE,
    REPORT
  } meas_state_t;

  typedef struct packed {
    logic [MEAS_WIDTH-1:0] width;
    logic                  overflow;
    logic                  timeout;
  } meas_result_t;

endpackage

// File: rtl/pulse_width_ctrl_sat_counter.sv
// Up-counter that clears on request and holds at MAX.
// The saturated flag is high whenever the count equals MAX.
module sat_counter #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             saturated
);

  assign saturated = (count == MAX);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !saturated) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pulse_width_ctrl.sv
// Pulse-width measurement sequencer: arm, wait for rising edge,
// count ticks until falling edge, report over valid/ready.
module pulse_width_ctrl
  import pipeline_types::*;
#(
  parameter int WIDTH         = 16,
  parameter int TIMEOUT_TICKS = 1000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  edges_t           i_edges,
  input  logic             i_count_enable,
  input  logic             i_arm,
  input  logic             i_continuous,
  input  logic             i_abort,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_width,
  output logic             o_overflow,
  output logic             o_timeout
);

  localparam int TW =
    (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);

  meas_state_t  state;
  meas_state_t  state_n;
  meas_result_t res;

  logic [WIDTH-1:0] wcnt;
  logic [WIDTH-1:0] wnext;
  logic             wsat;
  logic [TW-1:0]    tcnt;
  logic             tsat;
  logic             ovf;
  logic             valid_q;
  logic             busy_q;
  logic             in_armed;
  logic             in_meas;
  logic             rise_go;
  logic             fall_go;
  logic             t_hit;
  logic             tick_in;

  assign in_armed = (state == ARMED);
  assign in_meas  = (state == MEASURE);
  assign rise_go  = in_armed && i_edges.rising;
  assign fall_go  = in_meas && i_edges.falling;
  assign tick_in  = i_count_enable && !wsat;
  assign wnext    = wcnt + {{(WIDTH-1){1'b0}}, tick_in};

  // Counter sits one short of the limit; the next tick is the timeout.
  assign t_hit = (TIMEOUT_TICKS != 0) && i_count_enable && tsat;

  sat_counter #(
    .WIDTH (WIDTH)
  ) u_width_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .clear     (rise_go),
    .inc       (in_meas && i_count_enable),
    .count     (wcnt),
    .saturated (wsat)
  );

  sat_counter #(
    .WIDTH (TW),
    .MAX   (T_LAST)
  ) u_tmo_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .clear     (!in_armed),
    .inc       (in_armed && i_count_enable),
    .count     (tcnt),
    .saturated (tsat)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (i_arm) state_n = ARMED;
      end
      ARMED: begin
        if (i_edges.rising) state_n = MEASURE;
        else if (t_hit)     state_n = REPORT;
      end
      MEASURE: begin
        if (i_edges.falling) state_n = REPORT;
      end
      REPORT: begin
        if (valid_q && i_ready)
          state_n = i_continuous ? ARMED : IDLE;
      end
    endcase
    if (i_abort) state_n = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      valid_q <= (state_n == REPORT);
      busy_q  <= (state_n != IDLE);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ovf <= 1'b0;
    end else if (rise_go) begin
      ovf <= 1'b0;
    end else if (in_meas && i_count_enable && wsat) begin
      ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      res <= '0;
    end else begin
      unique case (1'b1)
        i_abort: begin
          res <= '0;
        end
        fall_go: begin
          res.width    <= MEAS_WIDTH'(wnext);
          res.overflow <= ovf || (i_count_enable && wsat);
          res.timeout  <= 1'b0;
        end
        (in_armed && !i_edges.rising && t_hit): begin
          res.width    <= '0;
          res.overflow <= 1'b0;
          res.timeout  <= 1'b1;
        end
        default: begin
          res <= res;
        end
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_valid    = valid_q;
  assign o_width    = res.width[WIDTH-1:0];
  assign o_overflow = res.overflow;
  assign o_timeout  = res.timeout;

endmodule

// File: tb/tb_pulse_width_ctrl.sv
// Bench for pulse_width_ctrl: a 16-bit instance and a 4-bit,
// 3-tick-timeout instance, checked against tick-count arithmetic.
module tb_pulse_width_ctrl;
  import pipeline_types::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  edges_t edg [2];
  logic   ce [2];
  logic   arm [2];
  logic   cont [2];
  logic   abort [2];
  logic   ready [2];
  logic   busy [2];
  logic   valid [2];
  logic   ovf [2];
  logic   tmo [2];
  logic [15:0] w0;
  logic [3:0]  w1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pulse_width_ctrl dut0 (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_edges        (edg[0]),
    .i_count_enable (ce[0]),
    .i_arm          (arm[0]),
    .i_continuous   (cont[0]),
    .i_abort        (abort[0]),
    .i_ready        (ready[0]),
    .o_busy         (busy[0]),
    .o_valid        (valid[0]),
    .o_width        (w0),
    .o_overflow     (ovf[0]),
    .o_timeout      (tmo[0])
  );

  pulse_width_ctrl #(
    .WIDTH         (4),
    .TIMEOUT_TICKS (3)
  ) dut1 (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_edges        (edg[1]),
    .i_count_enable (ce[1]),
    .i_arm          (arm[1]),
    .i_continuous   (cont[1]),
    .i_abort        (abort[1]),
    .i_ready        (ready[1]),
    .o_busy         (busy[1]),
    .o_valid        (valid[1]),
    .o_width        (w1),
    .o_overflow     (ovf[1]),
    .o_timeout      (tmo[1])
  );

  function automatic logic [31:0] getw(input int i);
    return (i == 0) ? {16'd0, w0} : {28'd0, w1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int i, input bit a, input bit r,
                     input bit f, input bit t, input bit ab);
    arm[i]         = a;
    edg[i].rising  = r;
    edg[i].falling = f;
    ce[i]          = t;
    abort[i]       = ab;
    step();
    arm[i]   = 1'b0;
    edg[i]   = '0;
    ce[i]    = 1'b0;
    abort[i] = 1'b0;
  endtask

  task automatic chk_idle_out(input string tag, input int i);
    chk({tag, "_busy"}, busy[i], 0);
    chk({tag, "_valid"}, valid[i], 0);
    chk({tag, "_width"}, getw(i), 0);
    chk({tag, "_ovf"}, ovf[i], 0);
    chk({tag, "_tmo"}, tmo[i], 0);
  endtask

  // len = cycles after the rising strobe up to and including falling.
  task automatic measure(input int i, input bit do_arm, input int gap,
                         input int len, input int pct, input bit rf_same,
                         input int hold);
    int  cnt;
    int  mx;
    int  ew;
    bit  t;
    mx = (i == 0) ? 65535 : 15;
    ready[i] = (hold == 0);
    if (do_arm) cyc(i, 1, 0, 0, 0, 0);
    for (int k = 0; k < gap; k++)
      cyc(i, 0, 0, 1'($urandom_range(0, 3) == 0), 0, 0);
    cyc(i, 0, 1, 0, 1'($urandom_range(0, 1)), 0);
    chk("rise_busy", busy[i], 1);
    chk("rise_valid", valid[i], 0);
    cnt = 0;
    for (int k = 1; k <= len; k++) begin
      t = ($urandom_range(1, 100) <= pct);
      cnt += int'(t);
      if (k < len) cyc(i, 0, 1'($urandom_range(0, 7) == 0), 0, t, 0);
      else         cyc(i, 0, rf_same, 1, t, 0);
    end
    ew = (cnt > mx) ? mx : cnt;
    chk("rep_valid", valid[i], 1);
    chk("rep_width", getw(i), ew);
    chk("rep_ovf", ovf[i], (cnt > mx) ? 1 : 0);
    chk("rep_tmo", tmo[i], 0);
    for (int k = 0; k < hold; k++) begin
      cyc(i, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 0);
      chk("hold_valid", valid[i], 1);
      chk("hold_width", getw(i), ew);
    end
    ready[i] = 1'b1;
    cyc(i, 0, 0, 0, 0, 0);
    chk("acc_valid", valid[i], 0);
    chk("acc_busy", busy[i], cont[i] ? 1 : 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      edg[i] = '0; ce[i] = 0; arm[i] = 0;
      cont[i] = 0; abort[i] = 0; ready[i] = 0;
    end
    step();
    step();
    chk_idle_out("rst0", 0);
    chk_idle_out("rst1", 1);
    rst_n = 1'b1;
    step();

    // arm at 0, rising at 10, ticks every 5, falling at 60
    ready[0] = 1'b1;
    for (int c = 0; c <= 60; c++)
      cyc(0, c == 0, c == 10, c == 60, (c > 0) && (c % 5 == 0), 0);
    chk("t1_valid", valid[0], 1);
    chk("t1_width", w0, 10);
    chk("t1_ovf", ovf[0], 0);
    chk("t1_tmo", tmo[0], 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t1_acc_valid", valid[0], 0);
    chk("t1_acc_busy", busy[0], 0);

    for (int n = 0; n < 6; n++)
      measure(0, 1, $urandom_range(0, 4), $urandom_range(1, 40),
              $urandom_range(20, 90), 0, $urandom_range(0, 3));
    for (int n = 0; n < 4; n++)
      measure(1, 1, $urandom_range(0, 3), $urandom_range(1, 14),
              $urandom_range(30, 100), 0, $urandom_range(0, 2));

    measure(1, 1, 2, 20, 100, 0, 0);
    measure(0, 1, 1, 5, 100, 1, 0);
    measure(0, 1, 2, 8, 50, 0, 20);

    // timeout after the 3rd armed tick
    ready[1] = 1'b1;
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    chk("to_early", valid[1], 0);
    cyc(1, 0, 0, 0, 1, 0);
    chk("to_valid", valid[1], 1);
    chk("to_flag", tmo[1], 1);
    chk("to_width", w1, 0);
    chk("to_ovf", ovf[1], 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("to_acc", busy[1], 0);

    // rising on the 3rd-tick cycle wins
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 1, 0);
    chk("rw_busy", busy[1], 1);
    chk("rw_valid", valid[1], 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 1, 0);
    chk("rw_no_to", valid[1], 0);
    cyc(1, 0, 0, 1, 0, 0);
    chk("rw_valid2", valid[1], 1);
    chk("rw_width", w1, 3);
    chk("rw_tmo", tmo[1], 0);
    cyc(1, 0, 0, 0, 0, 0);

    // continuous mode: widths 2, 7, 4
    cont[0] = 1'b1;
    measure(0, 1, 1, 2, 100, 0, 0);
    chk("c1_w_hold", w0, 2);
    measure(0, 0, 2, 7, 100, 0, 0);
    measure(0, 0, 1, 4, 100, 0, 0);

    // async reset mid-measure
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("ar_busy_pre", busy[0], 1);
    chk("ar_w_pre", w0, 4);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_out("ar", 0);
    #2 rst_n = 1'b1;
    step();
    chk("ar_post_busy", busy[0], 0);

    // abort mid-measure: no report
    ready[0] = 1'b1;
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    chk("ab_busy", busy[0], 0);
    chk("ab_valid", valid[0], 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("ab_no_rep", valid[0], 0);

    // abort beats acceptance in REPORT
    ready[0] = 1'b0;
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("abr_valid_pre", valid[0], 1);
    ready[0] = 1'b1;
    cyc(0, 0, 0, 0, 0, 1);
    chk("abr_valid", valid[0], 0);
    chk("abr_busy", busy[0], 0);
    chk("abr_width", w0, 0);
    cont[0] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulse_width_ctrl.md
# pulse_width_ctrl

Measurement sequencer for the count-enable datapath. Arms on request, waits for a rising edge on the conditioned input, then accumulates count-enable ticks until the falling edge. Reports the pulse width, overflow and timeout flags to the downstream consumer over a valid/ready handshake. Sits between the edge detector and count-enable generator on one side and the result FIFO/readout on the other.

## Interface
- WIDTH, 16: width of the pulse-width result in ticks.
- TIMEOUT_TICKS, 1000: count-enable ticks allowed in ARMED before a timeout report; 0 disables the timeout.
- i_clk  in  1  system clock; the block's only clock.
- i_reset_n  in  1  reset; asynchronous, active-low.
- i_edges  in  edges_t  edge strobes from the edge detector (.rising, .falling), each one cycle wide.
- i_count_enable  in  1  tick strobe from the count-enable generator.
- i_arm  in  1  single-cycle request to start one measurement.
- i_continuous  in  1  when 1, re-arms automatically after each accepted report.
- i_abort  in  1  forces return to IDLE from any state.
- i_ready  in  1  consumer accepts the report.
- o_busy  out  1  high in any state other than IDLE.
- o_valid  out  1  report valid.
- o_width  out  WIDTH  measured tick count.
- o_overflow  out  1  count saturated during the measurement.
- o_timeout  out  1  report produced by timeout; o_width = 0.

## Operation
- States are IDLE, ARMED, MEASURE and REPORT.
- IDLE:
  - i_arm moves to ARMED.
  - The timeout counter clears.
- ARMED:
  - Each i_count_enable increments the timeout counter.
  - i_edges.rising moves to MEASURE, clears the width counter to 0 and clears overflow.
  - When the timeout counter reaches TIMEOUT_TICKS (nonzero) with no rising edge, move to REPORT with o_timeout = 1 and o_width = 0.
  - If rising occurs on the same cycle as the timeout, rising wins.
  - i_edges.falling is ignored.
- MEASURE:
  - Each i_count_enable increments the width counter.
  - At all-ones the counter holds and sets overflow (it never wraps).
  - i_edges.falling moves to REPORT and latches the counter into o_width.
  - A tick on the same cycle as falling is included in the count.
  - i_edges.rising is ignored.
  - Rising and falling on the same cycle: falling is taken.
- Rising-edge cycle (ARMED to MEASURE): a tick on that cycle is not counted.
- REPORT:
  - o_valid = 1, with o_width, o_overflow and o_timeout held stable until accepted.
  - Accepted when o_valid and i_ready are both high. After acceptance, go to ARMED if i_continuous = 1, otherwise IDLE.
  - Edges and ticks are ignored.
- i_abort, any state:
  - Next state is IDLE. o_valid drops the next cycle and any pending report is discarded.
  - i_abort has priority over all other events, including acceptance and i_arm.
- i_arm outside IDLE is ignored.

## Timing
- Reset value of every output is 0. The reset state is IDLE.
- All outputs are registered.
- Rising-edge strobe at cycle N: MEASURE in N+1. The first countable tick is at N+1.
- Falling-edge strobe at cycle N: o_valid = 1 in N+1, with o_width equal to the ticks seen in cycles N+1 of the rising edge through N inclusive.
- o_valid deasserts the cycle after acceptance.
- Back-to-back operation (continuous mode): ARMED is entered the cycle after acceptance. A rising edge on the acceptance cycle is missed.
- No combinational path from i_ready to o_valid.
- Reset mid-measurement: immediate return to IDLE with all outputs 0.

## Structure
- edges_t comes from pipeline_types.
- Add to pipeline_types:
  - meas_state_t enum {IDLE, ARMED, MEASURE, REPORT}.
  - meas_result_t struct {width, overflow, timeout}, parameterised by a package-level MEAS_WIDTH default of 16.
- Sub-module sat_counter (WIDTH, clear, inc, saturated flag) is used twice: once for width and once for timeout.

## Test plan
- Arm, rising at cycle 10, ticks every 5 cycles, falling at cycle 60, i_ready = 1 -> o_valid at 61, o_width = 10, flags 0, then IDLE.
- WIDTH = 4, 20 ticks between rising and falling -> o_width = 15, o_overflow = 1.
- TIMEOUT_TICKS = 3, armed with no rising edge -> REPORT after the 3rd tick with o_timeout = 1 and o_width = 0. Repeat with rising on the 3rd-tick cycle -> MEASURE, no timeout.
- i_ready held low for 20 cycles during REPORT -> o_valid and o_width stable throughout. Edges during the hold -> no change. Accept -> IDLE.
- i_continuous = 1, three pulses widths 2, 7, 4 ticks -> three reports 2, 7, 4 in order. i_abort mid-MEASURE -> IDLE next cycle, no report.
- Tick coincident with rising -> not counted. Tick coincident with falling -> counted. Rising and falling same cycle in MEASURE -> report taken. Async reset pulse mid-MEASURE -> all outputs 0 immediately.
